// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Holds the FSM state encoding used by the top level.
package serial_subtractor_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/serial_subtractor_fs.sv
// Minterm-based full subtractor cell: x - y - z.
// Ports: x,y,z in; diff (x^y^z) and bout (borrow out) out.
module fs_usingdecoder (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic diff,
  output logic bout
);

  logic [7:0] m;

  always_comb begin
    m = '0;
    for (int k = 0; k < 8; k++) begin
      m[k] = ({x, y, z} == 3'(k));
    end
  end

  assign diff = m[1] | m[2] | m[4] | m[7];
  assign bout = m[1] | m[2] | m[3] | m[7];

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock.
// Ports: clk, rst, start, a, b in; busy, done, diff, borrow, ovf out.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] r_nxt;
  logic             a_msb;
  logic             b_msb;
  logic             bin;
  logic             d;
  logic             bout;
  logic             last;

  fs_usingdecoder u_fs (
    .x    (a_sh[0]),
    .y    (b_sh[0]),
    .z    (bin),
    .diff (d),
    .bout (bout)
  );

  // New bit enters at the MSB so the LSB-first result ends up aligned.
  generate
    if (WIDTH == 1) begin : g_w1
      assign r_nxt = d;
    end else begin : g_wn
      assign r_nxt = {d, r_sh[WIDTH-1:1]};
    end
  endgenerate

  assign last = (cnt == CW'(WIDTH - 1));
  assign busy = (state == ST_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      r_sh   <= '0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      bin    <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          r_sh <= r_nxt;
          bin  <= bout;
          cnt  <= cnt + 1'b1;
          if (last) begin
            state  <= ST_DONE;
            diff   <= r_nxt;
            borrow <= bout;
            ovf    <= (a_msb ^ b_msb) & (d ^ a_msb);
            done   <= 1'b1;
          end
        end
        default: begin
          if (start) begin
            state <= ST_SHIFT;
            a_sh  <= a;
            b_sh  <= b;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
            bin   <= 1'b0;
            cnt   <= '0;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8 and WIDTH=1).
// Random and directed operands against an arithmetic reference.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       busy8;
  logic       done8;
  logic [7:0] diff8;
  logic       borrow8;
  logic       ovf8;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       busy1;
  logic       done1;
  logic [0:0] diff1;
  logic       borrow1;
  logic       ovf1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk    (clk),
    .rst    (rst),
    .start  (start8),
    .a      (a8),
    .b      (b8),
    .busy   (busy8),
    .done   (done8),
    .diff   (diff8),
    .borrow (borrow8),
    .ovf    (ovf8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk    (clk),
    .rst    (rst),
    .start  (start1),
    .a      (a1),
    .b      (b1),
    .busy   (busy1),
    .done   (done1),
    .diff   (diff1),
    .borrow (borrow1),
    .ovf    (ovf1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on w-bit operands.
  function automatic void model(input int w, input int a, input int b,
                                output int d, output int br,
                                output int ov);
    int m, sa, sb, sr;
    m  = (1 << w) - 1;
    d  = (a - b) & m;
    br = (a < b) ? 1 : 0;
    sa = (a >= (1 << (w - 1))) ? a - (1 << w) : a;
    sb = (b >= (1 << (w - 1))) ? b - (1 << w) : b;
    sr = sa - sb;
    ov = (sr < -(1 << (w - 1)) || sr > (1 << (w - 1)) - 1) ? 1 : 0;
  endfunction

  // Called at a negedge; start is sampled on the following posedge.
  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    start8 = 1'b1;
    a8 = a;
    b8 = b;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom);
    b8 = 8'($urandom);
  endtask

  // Walks WIDTH busy cycles then checks the done cycle.
  task automatic finish(input string tag, input int a, input int b,
                        input bit inj);
    int ed, eb, eo;
    model(8, a, b, ed, eb, eo);
    for (int i = 0; i < 8; i++) begin
      chk({tag, ".busy"}, int'(busy8), 1);
      chk({tag, ".nodone"}, int'(done8), 0);
      if (inj && i == 2) begin
        start8 = 1'b1;
        a8 = 8'hFF;
        b8 = 8'h00;
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    chk({tag, ".done"}, int'(done8), 1);
    chk({tag, ".idle"}, int'(busy8), 0);
    chk({tag, ".diff"}, int'(diff8), ed);
    chk({tag, ".borrow"}, int'(borrow8), eb);
    chk({tag, ".ovf"}, int'(ovf8), eo);
  endtask

  task automatic op8(input string tag, input logic [7:0] a,
                     input logic [7:0] b);
    int ed, eb, eo;
    model(8, int'(a), int'(b), ed, eb, eo);
    launch(a, b);
    finish(tag, int'(a), int'(b), 1'b0);
    @(negedge clk);
    chk({tag, ".pulse"}, int'(done8), 0);
    chk({tag, ".hold"}, int'(diff8), ed);
  endtask

  task automatic op1(input string tag, input logic a, input logic b);
    int ed, eb, eo;
    model(1, int'(a), int'(b), ed, eb, eo);
    start1 = 1'b1;
    a1 = a;
    b1 = b;
    @(negedge clk);
    start1 = 1'b0;
    a1 = ~a;
    b1 = ~b;
    chk({tag, ".busy"}, int'(busy1), 1);
    chk({tag, ".nodone"}, int'(done1), 0);
    @(negedge clk);
    chk({tag, ".done"}, int'(done1), 1);
    chk({tag, ".diff"}, int'(diff1), ed);
    chk({tag, ".borrow"}, int'(borrow1), eb);
    chk({tag, ".ovf"}, int'(ovf1), eo);
    @(negedge clk);
    chk({tag, ".pulse"}, int'(done1), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ra, rb;
    rst = 1'b1;
    start8 = 1'b0;
    a8 = '0;
    b8 = '0;
    start1 = 1'b0;
    a1 = '0;
    b1 = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.busy", int'(busy8), 0);
    chk("rst.done", int'(done8), 0);
    chk("rst.diff", int'(diff8), 0);
    chk("rst.borrow", int'(borrow8), 0);
    chk("rst.ovf", int'(ovf8), 0);
    rst = 1'b0;
    @(negedge clk);

    op8("d05_03", 8'h05, 8'h03);
    op8("d03_05", 8'h03, 8'h05);
    op8("d80_01", 8'h80, 8'h01);
    op8("d7f_ff", 8'h7F, 8'hFF);

    launch(8'h05, 8'h03);
    finish("ignore", 32'h05, 32'h03, 1'b1);
    @(negedge clk);
    chk("ignore.pulse", int'(done8), 0);
    chk("ignore.busy", int'(busy8), 0);

    op8("d7f_ff2", 8'h7F, 8'hFF);
    launch(8'h05, 8'h03);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mid.busy", int'(busy8), 1);
    #1 rst = 1'b1;
    #1;
    chk("arst.busy", int'(busy8), 0);
    chk("arst.done", int'(done8), 0);
    chk("arst.diff", int'(diff8), 0);
    chk("arst.borrow", int'(borrow8), 0);
    chk("arst.ovf", int'(ovf8), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    op8("d10_10", 8'h10, 8'h10);

    launch(8'h3C, 8'h5A);
    finish("b2b1", 32'h3C, 32'h5A, 1'b0);
    launch(8'hC8, 8'h64);
    finish("b2b2", 32'hC8, 32'h64, 1'b0);
    @(negedge clk);
    chk("b2b.pulse", int'(done8), 0);

    for (int i = 0; i < 24; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      op8($sformatf("rnd%0d", i), ra, rb);
    end

    op1("w1_0_1", 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      op1($sformatf("w1_%0d", i), 1'(i >> 1), 1'(i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
